// File: rtl/calc_pkg.sv
// Shared constants and types for the round-robin Calculator scheduler.
package calc_pkg;

  localparam int CMD_W = 18;
  localparam int RES_W = 16;

  // Command layout: {op, a, b}
  localparam int OP_MSB = 17;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 0;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/calc_rr_sched_if.sv
// Requester command bus and response bus of the Calculator scheduler.
interface calc_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]                 req_valid;
  logic [calc_pkg::CMD_W*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0]                 req_ready;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [IDW-1:0]                   rsp_id;
  logic [calc_pkg::RES_W-1:0]       rsp_result;
  logic                             rsp_neg;
  logic                             rsp_err;

  modport master (
    output req_valid, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_err
  );

endinterface

// File: rtl/calc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module calc_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   id,
  output logic             any
);

  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/calc_rr_sched.sv
// Round-robin scheduler sharing one Calculator among N_REQ requesters.
// Optional per-requester completion counters on stat_done: define CALC_RR_SCHED_STATS_EN.
//
// state  | meaning
// IDLE   | offering one-hot grant, waiting for an accepted command
// EXEC   | latched command driven on calc_din, counting CALC_LAT
// RESP   | response held on rsp_* until rsp_ready
module calc_rr_sched
  import calc_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CALC_LAT = 2,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  calc_rr_sched_if.slave   bus,
  output logic [CMD_W-1:0] calc_din,
  input  logic [RES_W-1:0] calc_result,
  input  logic             calc_neg
`ifdef CALC_RR_SCHED_STATS_EN
  ,
  output logic [16*N_REQ-1:0] stat_done
`endif
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_RESP = ST_RESP;
  localparam int         CW     = (CALC_LAT < 1) ? 1 : $clog2(CALC_LAT + 1);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CMD_W-1:0] din_q, din_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_neg_q, rsp_neg_d;
  logic             rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_id;
  logic             pick_any;
  logic [CMD_W-1:0] pick_cmd;
  logic             rsp_hs;

  calc_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  assign pick_cmd = bus.req_cmd[int'(pick_id)*CMD_W +: CMD_W];
  assign rsp_hs   = rsp_valid_q && bus.rsp_ready;

  // Grant is withheld during reset so nothing looks accepted in the reset cycle.
  assign bus.req_ready  = (state_q == S_IDLE && !reset) ? pick_gnt : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_neg    = rsp_neg_q;
  assign bus.rsp_err    = rsp_err_q;
  assign calc_din       = din_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    din_d        = din_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          rsp_id_d = pick_id;
          if (pick_cmd[OP_MSB:OP_LSB] == OP_RSVD) begin
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_neg_d    = 1'b0;
            state_d      = S_RESP;
          end else begin
            din_d     = pick_cmd;
            cnt_d     = '0;
            rsp_err_d = 1'b0;
            state_d   = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == CW'(CALC_LAT)) begin
          rsp_result_d = calc_result;
          rsp_neg_d    = calc_neg;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == IDW'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      din_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_neg_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      din_q        <= din_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef CALC_RR_SCHED_STATS_EN
  logic [16*N_REQ-1:0] stat_q, stat_d;

  // Every completed handshake counts, error responses included; wraps at 16 bits.
  always_comb begin
    stat_d = stat_q;
    if (rsp_hs) begin
      stat_d[int'(rsp_id_q)*16 +: 16] = stat_q[int'(rsp_id_q)*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_done = stat_q;
`endif

endmodule
